// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - two-port round-robin arbiter sharing one cache word port
// Optional hierarchical statistics counters are enabled with CACHE_ARB_STATS_EN.
module cache_arbiter #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int STAT_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] p0_addr,
  input  logic                p0_rd_req,
  input  logic                p0_wr_req,
  input  logic [DATA_LEN-1:0] p0_wr_data,
  output logic                p0_miss,
  output logic [DATA_LEN-1:0] p0_rd_data,
  output logic                p0_rd_valid,
  input  logic [ADDR_LEN-1:0] p1_addr,
  input  logic                p1_rd_req,
  input  logic                p1_wr_req,
  input  logic [DATA_LEN-1:0] p1_wr_data,
  output logic                p1_miss,
  output logic [DATA_LEN-1:0] p1_rd_data,
  output logic                p1_rd_valid,
  output logic [ADDR_LEN-1:0] cache_addr,
  output logic                cache_rd_req,
  output logic                cache_wr_req,
  output logic [DATA_LEN-1:0] cache_wr_data,
  input  logic                cache_miss,
  input  logic [DATA_LEN-1:0] cache_rd_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  typedef logic [STAT_LEN-1:0] stat_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   req0, req1;
  logic   acc0, acc1;

  assign req0 = p0_rd_req | p0_wr_req;
  assign req1 = p1_rd_req | p1_wr_req;
  assign acc0 = (state == BUSY0) & req0 & ~cache_miss;
  assign acc1 = (state == BUSY1) & req1 & ~cache_miss;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Accept and abandon both return to IDLE; only a stalled live request holds the grant.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 & req1)  state_nxt = last_grant ? BUSY0 : BUSY1;
        else if (req0)    state_nxt = BUSY0;
        else if (req1)    state_nxt = BUSY1;
      end
      BUSY0:   if (~req0 | ~cache_miss) state_nxt = IDLE;
      BUSY1:   if (~req1 | ~cache_miss) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cache_addr    = '0;
    cache_rd_req  = 1'b0;
    cache_wr_req  = 1'b0;
    cache_wr_data = '0;
    case (state)
      BUSY0: begin
        cache_addr    = p0_addr;
        cache_rd_req  = p0_rd_req;
        cache_wr_req  = p0_wr_req & ~p0_rd_req;
        cache_wr_data = p0_wr_data;
      end
      BUSY1: begin
        cache_addr    = p1_addr;
        cache_rd_req  = p1_rd_req;
        cache_wr_req  = p1_wr_req & ~p1_rd_req;
        cache_wr_data = p1_wr_data;
      end
      default: ;
    endcase
    p0_miss = req0 & ~((state == BUSY0) & ~cache_miss);
    p1_miss = req1 & ~((state == BUSY1) & ~cache_miss);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= 1'b1;
      p0_rd_valid <= 1'b0;
      p1_rd_valid <= 1'b0;
    end else begin
      p0_rd_valid <= acc0 & p0_rd_req;
      p1_rd_valid <= acc1 & p1_rd_req;
      if (acc0)      last_grant <= 1'b0;
      else if (acc1) last_grant <= 1'b1;
    end
  end

  assign p0_rd_data = cache_rd_data;
  assign p1_rd_data = cache_rd_data;

`ifdef CACHE_ARB_STATS_EN
  stat_t stat_grant0, stat_grant1, stat_wait0, stat_wait1, stat_conflict;

  function automatic stat_t sat_inc(input stat_t v, input logic en);
    stat_t one;
    one = '0;
    one[0] = 1'b1;
    return (en && (v != '1)) ? v + one : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_wait0    <= '0;
      stat_wait1    <= '0;
      stat_conflict <= '0;
    end else begin
      stat_grant0   <= sat_inc(stat_grant0, acc0);
      stat_grant1   <= sat_inc(stat_grant1, acc1);
      stat_wait0    <= sat_inc(stat_wait0, p0_miss);
      stat_wait1    <= sat_inc(stat_wait1, p1_miss);
      stat_conflict <= sat_inc(stat_conflict, (state == IDLE) & req0 & req1);
    end
  end
`endif

endmodule
